fetch_sequencer: RTL

- Instruction fetch/issue stage directly upstream of memory_controller.
- Owns the program counter and drives memory_controller's program_counter_address and microcode_control.
- Reads instruction words (and an optional operand word via PEEK) from program RAM, then presents them to the execute stage with a valid/done handshake.

---
 rtl/fetch_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: owns the PC, reads one- and two-word instructions
// from synchronous program RAM and hands them to execute. Optional counter: FETCH_SEQ_RETIRE_COUNT_EN.
module fetch_sequencer #(
   parameter int                         ADDRESS_WIDTH = 16,
   parameter int                         DATA_WIDTH    = 16,
   parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = {ADDRESS_WIDTH{1'b0}}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stall,
   input  logic [DATA_WIDTH-1:0]     p_ram_read_data,
   input  logic [2:0]                exec_mem_op,
   input  logic                      exec_done,
   input  logic                      jump_valid,
   input  logic [ADDRESS_WIDTH-1:0]  jump_address,
   output logic [ADDRESS_WIDTH-1:0]  program_counter_address,
   output logic [2:0]                microcode_control,
   output logic [DATA_WIDTH-1:0]     instruction,
   output logic [DATA_WIDTH-1:0]     operand,
   output logic                      instr_valid,
   output logic                      halted,
   output logic [31:0]               retired_count
);

   typedef enum logic [2:0] {
      ST_FETCH      = 3'd0,
      ST_FETCH_WAIT = 3'd1,
      ST_PEEK       = 3'd2,
      ST_PEEK_WAIT  = 3'd3,
      ST_ISSUE      = 3'd4,
      ST_HALTED     = 3'd5
   } state_t;

   localparam logic [2:0] MC_PASS_PC = 3'd0;
   localparam logic [2:0] MC_PEEK    = 3'd5;

   state_t                      state_r;
   state_t                      next_state_s;
   logic [2:0]                  mc_s;
   logic [ADDRESS_WIDTH-1:0]    pc_r;
   logic [DATA_WIDTH-1:0]       instruction_r;
   logic [DATA_WIDTH-1:0]       operand_r;
   logic                        two_word_r;
   logic                        instr_valid_r;
   logic                        halted_r;
   logic                        is_halt_s;
   logic                        is_two_word_s;
   logic                        retire_s;

   // HALT takes priority over the two-word marker, which shares bit 15.
   assign is_halt_s     = (p_ram_read_data[15:8] == 8'hFF);
   assign is_two_word_s = p_ram_read_data[15] & ~is_halt_s;
   assign retire_s      = (state_r == ST_ISSUE) & exec_done;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode and memory-controller op selection.
   always_comb begin
      next_state_s = state_r;
      mc_s         = MC_PASS_PC;
      case (state_r)
         ST_FETCH: begin
            if (stall) next_state_s = ST_FETCH;
            else       next_state_s = ST_FETCH_WAIT;
         end
         ST_FETCH_WAIT: begin
            if (is_halt_s)          next_state_s = ST_HALTED;
            else if (is_two_word_s) next_state_s = ST_PEEK;
            else                    next_state_s = ST_ISSUE;
         end
         ST_PEEK: begin
            mc_s = MC_PEEK;
            if (stall) next_state_s = ST_PEEK;
            else       next_state_s = ST_PEEK_WAIT;
         end
         ST_PEEK_WAIT: begin
            mc_s         = MC_PEEK;
            next_state_s = ST_ISSUE;
         end
         ST_ISSUE: begin
            mc_s = exec_mem_op;
            if (exec_done) next_state_s = ST_FETCH;
            else           next_state_s = ST_ISSUE;
         end
         ST_HALTED: begin
            next_state_s = ST_HALTED;
         end
         default: begin
            next_state_s = ST_FETCH;
         end
      endcase
   end

   // Datapath: PC, captured words and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r          <= RESET_VECTOR;
         instruction_r <= {DATA_WIDTH{1'b0}};
         operand_r     <= {DATA_WIDTH{1'b0}};
         two_word_r    <= 1'b0;
         instr_valid_r <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_FETCH_WAIT: begin
               instruction_r <= p_ram_read_data;
               two_word_r    <= is_two_word_s;
               if (is_halt_s) begin
                  halted_r <= 1'b1;
               end else if (!is_two_word_s) begin
                  operand_r     <= {DATA_WIDTH{1'b0}};
                  instr_valid_r <= 1'b1;
               end
            end
            ST_PEEK_WAIT: begin
               operand_r     <= p_ram_read_data;
               instr_valid_r <= 1'b1;
            end
            ST_ISSUE: begin
               if (exec_done) begin
                  instr_valid_r <= 1'b0;
                  if (jump_valid) pc_r <= jump_address;
                  else            pc_r <= pc_r + ADDRESS_WIDTH'(two_word_r ? 2'd2 : 2'd1);
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FETCH_SEQ_RETIRE_COUNT_EN
   logic [31:0] retired_r;

   // Retired-instruction counter; wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_r <= 32'd0;
      end else if (retire_s) begin
         retired_r <= retired_r + 32'd1;
      end else begin
         retired_r <= retired_r;
      end
   end

   assign retired_count = retired_r;
`else
   logic unused_retire_s;
   assign unused_retire_s = retire_s;
   assign retired_count   = 32'd0;
`endif

   assign program_counter_address = pc_r;
   assign microcode_control       = mc_s;
   assign instruction             = instruction_r;
   assign operand                 = operand_r;
   assign instr_valid             = instr_valid_r;
   assign halted                  = halted_r;

endmodule
